// File: rtl/pipe_ctrl_types.sv
// Shared stage indices, arbitration case enum and perf increment struct for pipe_ctrl.
// PIPE_PERF_EN adds the perf_cnt_t increment struct used by pipe_perf.
package pipe_ctrl_types;

  localparam int unsigned STG_PC     = 0;
  localparam int unsigned STG_IFID   = 1;
  localparam int unsigned STG_IDEX   = 2;
  localparam int unsigned STG_EXMEM  = 3;
  localparam int unsigned STG_MEMWB  = 4;
  localparam int unsigned NUM_STAGES = STG_MEMWB + 1;

  // Arbitration outcome for the current cycle, highest priority first.
  typedef enum logic [2:0] {
    CTRL_RST,
    CTRL_FREEZE,
    CTRL_REDIR,
    CTRL_HAZ,
    CTRL_RUN
  } ctrl_case_e;

`ifdef PIPE_PERF_EN
  // One increment strobe per performance counter.
  typedef struct packed {
    logic cycle;
    logic mem_stall;
    logic haz_stall;
    logic br_total;
    logic br_wrong;
  } perf_cnt_t;
`endif

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath <-> pipe_ctrl bundle: memory handshakes, hazard/redirect requests, load/flush strobes.
// PIPE_PERF_EN adds the performance counter outputs.
interface pipe_ctrl_if #(
  parameter int unsigned STAGES = 5
`ifdef PIPE_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
);
  logic              imem_req;
  logic              imem_resp;
  logic              dmem_req;
  logic              dmem_resp;
  logic              hazard_stall;
  logic              redirect_valid;
  logic [31:0]       redirect_target;
  logic              resolve_is_br;
  logic [STAGES-1:0] stage_load;
  logic [STAGES-1:0] stage_flush;
  logic              pc_redirect;
  logic [31:0]       pc_target;
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0]  perf_cycles;
  logic [CNT_W-1:0]  perf_mem_stall;
  logic [CNT_W-1:0]  perf_haz_stall;
  logic [CNT_W-1:0]  perf_br_total;
  logic [CNT_W-1:0]  perf_br_wrong;
`endif

  // Datapath side.
  modport master (
    output imem_req, imem_resp, dmem_req, dmem_resp, hazard_stall,
           redirect_valid, redirect_target, resolve_is_br,
    input  stage_load, stage_flush, pc_redirect, pc_target
`ifdef PIPE_PERF_EN
    , input perf_cycles, perf_mem_stall, perf_haz_stall, perf_br_total, perf_br_wrong
`endif
  );

  // Controller side.
  modport slave (
    input  imem_req, imem_resp, dmem_req, dmem_resp, hazard_stall,
           redirect_valid, redirect_target, resolve_is_br,
    output stage_load, stage_flush, pc_redirect, pc_target
`ifdef PIPE_PERF_EN
    , output perf_cycles, perf_mem_stall, perf_haz_stall, perf_br_total, perf_br_wrong
`endif
  );
endinterface

// File: rtl/pipe_perf.sv
// Five free-running wrap-around performance counters, cleared by synchronous active-low rst.
// Only instantiated when PIPE_PERF_EN is defined.
module pipe_perf
  import pipe_ctrl_types::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  perf_cnt_t        inc,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] mem_stall,
  output logic [CNT_W-1:0] haz_stall,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_wrong
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycles    <= '0;
      mem_stall <= '0;
      haz_stall <= '0;
      br_total  <= '0;
      br_wrong  <= '0;
    end else begin
      cycles    <= cycles    + CNT_W'(inc.cycle);
      mem_stall <= mem_stall + CNT_W'(inc.mem_stall);
      haz_stall <= haz_stall + CNT_W'(inc.haz_stall);
      br_total  <= br_total  + CNT_W'(inc.br_total);
      br_wrong  <= br_wrong  + CNT_W'(inc.br_wrong);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline load/flush controller: arbitrates reset, memory freeze, redirect and hazard bubble,
// and holds a redirect raised during a freeze until the freeze ends. PIPE_PERF_EN adds counters.
module pipe_ctrl
  import pipe_ctrl_types::*;
#(
  parameter int unsigned STAGES      = NUM_STAGES,
  parameter int unsigned HAZ_STAGE   = STG_EXMEM,
  parameter int unsigned REDIR_STAGE = STG_EXMEM
`ifdef PIPE_PERF_EN
  , parameter int unsigned CNT_W     = 32
`endif
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  if (HAZ_STAGE == 0 || HAZ_STAGE > STAGES - 1) begin : g_bad_haz
    $fatal(1, "pipe_ctrl: HAZ_STAGE out of range");
  end
  if (REDIR_STAGE == 0 || REDIR_STAGE > STAGES - 1) begin : g_bad_redir
    $fatal(1, "pipe_ctrl: REDIR_STAGE out of range");
  end

  localparam logic [STAGES-1:0] ALL1       = '1;
  localparam logic [STAGES-1:0] REDIR_MASK = (ALL1 >> (STAGES - 1 - REDIR_STAGE))
                                             & ~(STAGES'(1) << STG_PC);
  localparam logic [STAGES-1:0] HAZ_LOAD   = ALL1 << HAZ_STAGE;
  localparam logic [STAGES-1:0] HAZ_FLUSH  = STAGES'(1) << HAZ_STAGE;

  logic        mem_stall;
  logic        eff_v;
  logic [31:0] tgt;
  logic        pend_v;
  logic [31:0] pend_tgt;
  ctrl_case_e  ctrl_case;

  always_comb begin
    mem_stall = (bus.imem_req & ~bus.imem_resp) | (bus.dmem_req & ~bus.dmem_resp);
    eff_v     = pend_v | bus.redirect_valid;
    tgt       = pend_v ? pend_tgt : bus.redirect_target;
  end

  // Priority decode of the current cycle.
  always_comb begin
    ctrl_case = CTRL_RUN;
    if (!rst)                  ctrl_case = CTRL_RST;
    else if (mem_stall)        ctrl_case = CTRL_FREEZE;
    else if (eff_v)            ctrl_case = CTRL_REDIR;
    else if (bus.hazard_stall) ctrl_case = CTRL_HAZ;
  end

  always_comb begin
    bus.stage_load  = '0;
    bus.stage_flush = '0;
    bus.pc_redirect = 1'b0;
    bus.pc_target   = '0;
    unique case (ctrl_case)
      CTRL_RST:    bus.stage_flush = ALL1;
      CTRL_FREEZE: ;
      CTRL_REDIR: begin
        bus.stage_load  = ALL1;
        bus.stage_flush = REDIR_MASK;
        bus.pc_redirect = 1'b1;
        bus.pc_target   = {tgt[31:1], 1'b0};
      end
      CTRL_HAZ: begin
        bus.stage_load  = HAZ_LOAD;
        bus.stage_flush = HAZ_FLUSH;
      end
      CTRL_RUN:    bus.stage_load = ALL1;
      default:     bus.stage_flush = ALL1;
    endcase
  end

  // A held instruction may re-assert its redirect each frozen cycle; the latest one wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_v   <= 1'b0;
      pend_tgt <= '0;
    end else if (mem_stall) begin
      if (bus.redirect_valid) begin
        pend_v   <= 1'b1;
        pend_tgt <= bus.redirect_target;
      end
    end else begin
      pend_v <= 1'b0;
    end
  end

`ifdef PIPE_PERF_EN
  logic      pend_br;
  perf_cnt_t perf_inc;

  always_ff @(posedge clk) begin
    if (!rst)                              pend_br <= 1'b0;
    else if (mem_stall && bus.redirect_valid) pend_br <= bus.resolve_is_br;
  end

  always_comb begin
    perf_inc           = '0;
    perf_inc.cycle     = 1'b1;
    perf_inc.mem_stall = (ctrl_case == CTRL_FREEZE);
    perf_inc.haz_stall = (ctrl_case == CTRL_HAZ);
    perf_inc.br_total  = rst & ~mem_stall & bus.resolve_is_br;
    perf_inc.br_wrong  = (ctrl_case == CTRL_REDIR) & (bus.resolve_is_br | (pend_v & pend_br));
  end

  pipe_perf #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .rst       (rst),
    .inc       (perf_inc),
    .cycles    (bus.perf_cycles),
    .mem_stall (bus.perf_mem_stall),
    .haz_stall (bus.perf_haz_stall),
    .br_total  (bus.perf_br_total),
    .br_wrong  (bus.perf_br_wrong)
  );
`endif

  logic unused_ok;
  assign unused_ok = ^{tgt[0]
`ifndef PIPE_PERF_EN
                      , bus.resolve_is_br
`endif
                      };

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues hand-computed expectations, the monitor checks them.
// With PIPE_PERF_EN a second instance with 4-bit counters exercises counter wrap.
module tb_pipe_ctrl;
  import pipe_ctrl_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.STAGES(5)
`ifdef PIPE_PERF_EN
    , .CNT_W(32)
`endif
  ) bus ();

  pipe_ctrl #(.STAGES(5), .HAZ_STAGE(3), .REDIR_STAGE(3)
`ifdef PIPE_PERF_EN
    , .CNT_W(32)
`endif
  ) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef PIPE_PERF_EN
  pipe_ctrl_if #(.STAGES(5), .CNT_W(4)) bus4 ();
  assign bus4.imem_req        = bus.imem_req;
  assign bus4.imem_resp       = bus.imem_resp;
  assign bus4.dmem_req        = bus.dmem_req;
  assign bus4.dmem_resp       = bus.dmem_resp;
  assign bus4.hazard_stall    = bus.hazard_stall;
  assign bus4.redirect_valid  = bus.redirect_valid;
  assign bus4.redirect_target = bus.redirect_target;
  assign bus4.resolve_is_br   = bus.resolve_is_br;

  pipe_ctrl #(.STAGES(5), .HAZ_STAGE(3), .REDIR_STAGE(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4));
`endif

  typedef struct {
    string       nm;
    logic [4:0]  ld;
    logic [4:0]  fl;
    logic        pcr;
    logic [31:0] pct;
    bit          chk_perf;
    logic [31:0] e_cyc, e_mem, e_haz, e_br, e_wr;
    logic [3:0]  e_cyc4;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents one result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".load"},   32'(bus.stage_load),  32'(e.ld));
        chk({e.nm, ".flush"},  32'(bus.stage_flush), 32'(e.fl));
        chk({e.nm, ".pcr"},    32'(bus.pc_redirect), 32'(e.pcr));
        chk({e.nm, ".target"}, bus.pc_target,        e.pct);
`ifdef PIPE_PERF_EN
        if (e.chk_perf) begin
          chk({e.nm, ".cycles"}, bus.perf_cycles,      e.e_cyc);
          chk({e.nm, ".mem"},    bus.perf_mem_stall,   e.e_mem);
          chk({e.nm, ".haz"},    bus.perf_haz_stall,   e.e_haz);
          chk({e.nm, ".br"},     bus.perf_br_total,    e.e_br);
          chk({e.nm, ".wrong"},  bus.perf_br_wrong,    e.e_wr);
          chk({e.nm, ".cyc4"},   32'(bus4.perf_cycles), 32'(e.e_cyc4));
        end
`endif
      end
    end
  end

  task automatic step(input string nm, input logic r, ir, irs, dr, drs, hz, rv,
                      input logic [31:0] rt, input logic br,
                      input logic [4:0] eld, efl, input logic epcr, input logic [31:0] epct);
    exp_t e;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.imem_req        = ir;
    bus.imem_resp       = irs;
    bus.dmem_req        = dr;
    bus.dmem_resp       = drs;
    bus.hazard_stall    = hz;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.resolve_is_br   = br;
    e.nm = nm; e.ld = eld; e.fl = efl; e.pcr = epcr; e.pct = epct;
    e.chk_perf = 1'b0;
    e.e_cyc = '0; e.e_mem = '0; e.e_haz = '0; e.e_br = '0; e.e_wr = '0; e.e_cyc4 = '0;
    q.push_back(e);
  endtask

  task automatic norm(input string nm, input logic br);
    step(nm, 1, 0, 0, 0, 0, 0, 0, 32'h0, br, 5'b11111, 5'b00000, 0, 32'h0);
  endtask

  task automatic haz(input string nm);
    step(nm, 1, 0, 0, 0, 0, 1, 0, 32'h0, 0, 5'b11000, 5'b01000, 0, 32'h0);
  endtask

  task automatic rst_cyc(input string nm, input logic rv, input logic [31:0] rt);
    step(nm, 0, 0, 0, 0, 0, 0, rv, rt, rv, 5'b00000, 5'b11111, 0, 32'h0);
  endtask

  task automatic dstall(input string nm, input logic rv, input logic [31:0] rt, input logic br);
    step(nm, 1, 0, 0, 1, 0, 0, rv, rt, br, 5'b00000, 5'b00000, 0, 32'h0);
  endtask

  task automatic istall(input string nm, input logic rv, input logic [31:0] rt, input logic hz);
    step(nm, 1, 1, 0, 0, 0, hz, rv, rt, 0, 5'b00000, 5'b00000, 0, 32'h0);
  endtask

`ifdef PIPE_PERF_EN
  task automatic perf_chk(input string nm, input logic [31:0] c, m, h, b, w, input logic [3:0] c4);
    exp_t e;
    norm(nm, 0);
    e = q.pop_back();
    e.chk_perf = 1'b1;
    e.e_cyc = c; e.e_mem = m; e.e_haz = h; e.e_br = b; e.e_wr = w; e.e_cyc4 = c4;
    q.push_back(e);
  endtask
`endif

  initial begin
    rst = 1'b0;
    bus.imem_req = 0; bus.imem_resp = 0; bus.dmem_req = 0; bus.dmem_resp = 0;
    bus.hazard_stall = 0; bus.redirect_valid = 0; bus.redirect_target = '0; bus.resolve_is_br = 0;

    // Reset, with a redirect that must be discarded.
    rst_cyc("rst0", 0, 32'h0);
    rst_cyc("rst1_redir", 1, 32'h500);
    norm("release", 0);

    haz("hazard");
    norm("after_haz", 0);
    step("redir_haz", 1, 0, 0, 0, 0, 1, 1, 32'h1235, 0, 5'b11111, 5'b01110, 1, 32'h1234);
    norm("after_redir", 0);

    // Redirect captured under a data-memory freeze.
    dstall("frz1", 1, 32'h80, 1);
    dstall("frz2", 0, 32'h0, 0);
    dstall("frz3", 0, 32'h0, 0);
    dstall("frz4", 0, 32'h0, 0);
    step("frz_release", 1, 0, 0, 1, 1, 0, 0, 32'h0, 0, 5'b11111, 5'b01110, 1, 32'h80);
    norm("pend_clr", 0);

    // Overwrite under freeze, then pending target beats a fresh redirect.
    istall("ov1_haz", 1, 32'h100, 1);
    istall("ov2", 1, 32'h205, 0);
    step("pend_prio", 1, 1, 1, 0, 0, 0, 1, 32'h300, 0, 5'b11111, 5'b01110, 1, 32'h204);
    norm("pend_clr2", 0);

    // Counter window: 10 cycles after reset.
    rst_cyc("perf_rst", 0, 32'h0);
    norm("p1_br", 1);
    dstall("p2_mem_br", 0, 32'h0, 1);
    dstall("p3_mem", 0, 32'h0, 0);
    istall("p4_mem", 0, 32'h0, 0);
    haz("p5_haz");
    haz("p6_haz");
    norm("p7_br", 1);
    step("p8_mispredict", 1, 0, 0, 0, 0, 0, 1, 32'h40, 1, 5'b11111, 5'b01110, 1, 32'h40);
    norm("p9_br", 1);
    norm("p10", 0);
`ifdef PIPE_PERF_EN
    perf_chk("perf10", 32'd10, 32'd3, 32'd2, 32'd4, 32'd1, 4'd10);
    for (int i = 0; i < 6; i++) norm("pad", 0);
    perf_chk("perf17", 32'd17, 32'd3, 32'd2, 32'd4, 32'd1, 4'd1);
`else
    for (int i = 0; i < 7; i++) norm("pad", 0);
`endif

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
